alarm_snooze_ctrl: RTL and testbench
====================================

Name: alarm_snooze_ctrl

Overview:
Downstream consumer of the clock/alarm datapath. It replaces the bare alarm comparator and Buzz gating with a sequenced controller: ring on alarm match, bounded ring duration, minute-based snooze with a snooze limit, and dismiss via Alarmon.
It is clocked by the 1/sec Pulse and driven by the time and alarm counter outputs plus the seconds-rollover carry. Its buzz output drives the top-level Buzz.

Parameters:
SNOOZE_MIN, 9, snooze length in minute boundaries; legal range 1..15
RING_SEC, 60, seconds of ringing before auto-silence; legal range 2..127
MAX_SNOOZE, 3, snoozes allowed per alarm event; legal range 0..3

Ports:
clk  input  1  Pulse, 1 tick/sec; all state on rising edge
rst  input  1  asynchronous, active-high reset
alarmon  input  1  alarm enable; low = dismiss/disarm
snooze  input  1  snooze button level
smax  input  1  seconds counter at 59 (minute-boundary tick)
tmin  input  7  time minutes 0..59
thrs  input  7  time hours 0..11
tpm  input  1  time PM
amin  input  7  alarm minutes 0..59
ahrs  input  7  alarm hours 0..11
apm  input  1  alarm PM
buzz  output  1  alarm sounding
snoozing  output  1  in SNOOZE state
snooze_left  output  4  minute boundaries remaining in SNOOZE; 0 otherwise

Behaviour:
- match = (tmin==amin) && (thrs==ahrs) && (tpm==apm), combinational. match_q is its registered copy.
- trig = alarmon && match && !match_q, a rising edge of match.
- snz_edge = snooze && !snooze_q. snooze_q is the registered copy of snooze.
- States: IDLE, RING, SNOOZE. buzz = (state==RING). snoozing = (state==SNOOZE). All outputs are decoded from registers; there is no combinational input-to-output path.
- Reset values: state=IDLE, buzz=0, snoozing=0, snooze_left=0, ring_ct=0, snz_used=0, snooze_q=0.
- Reset value of match_q is 1. This suppresses a spurious ring after reset, when time and alarm both read 12:00 AM.
- Priority, highest first, evaluated every cycle: alarmon==0 forces IDLE, clears ring_ct, snooze_left and snz_used; then the state rules below.
- IDLE:
  - trig → RING next cycle, ring_ct=0, snz_used=0. buzz is high on the cycle after the edge where match first goes true (latency 1 tick).
- RING:
  - ring_ct increments each cycle.
  - snz_edge with snz_used<MAX_SNOOZE → SNOOZE, snooze_left=SNOOZE_MIN, snz_used+1.
  - snz_edge with snz_used==MAX_SNOOZE → IDLE (dismiss).
  - Otherwise, ring_ct==RING_SEC-1 → IDLE (auto-silence; buzz high exactly RING_SEC cycles).
  - A snz_edge on the same cycle as the timeout: snooze wins.
  - trig while in RING is ignored; ring_ct is not restarted.
- SNOOZE:
  - On each smax cycle, snooze_left decrements.
  - smax && snooze_left==1 → RING, ring_ct=0, snooze_left=0. Re-ring occurs at the SNOOZE_MIN-th minute boundary after entry, i.e. between SNOOZE_MIN-1 and SNOOZE_MIN minutes.
  - snz_edge and trig are ignored in SNOOZE.
- A snooze button held high from before RING does not count as a press; a new rising edge is required.
- Time changes made via Timeset are not distinguished. Any match rising edge while alarmon=1 rings.
- ring_ct width is $clog2(RING_SEC); ring_ct never exceeds RING_SEC-1. snz_used is 2 bits.
- Asynchronous reset mid-RING or mid-SNOOZE returns to IDLE immediately, with buzz low asynchronously.

Test Plan:
- Alarm 7:30 AM, alarmon=1; time advances 7:29:59→7:30:00 → buzz=1 on the 7:30:00 tick's following cycle; buzz stays high 60 ticks, then 0; no re-ring at 7:30 while match persists.
- Reset with all counters 0 (12:00 AM both), alarmon=1 → buzz stays 0 for ≥5 ticks.
- RING at tick 10, snooze rising edge at tick 15 → buzz=0, snoozing=1, snooze_left=9; after 9 smax pulses → buzz=1 and snooze_left=0 on the cycle following the 9th smax.
- MAX_SNOOZE=3: snooze three times, then a fourth snooze edge during RING → IDLE, buzz=0, snoozing=0; no further ring until the next match edge.
- During RING, drop alarmon for one tick → buzz=0 next cycle, state IDLE; raising alarmon again while match is still true → no ring.
- Snooze edge on the cycle where ring_ct==RING_SEC-1 → SNOOZE entered (snoozing=1), not IDLE; snooze held high across the next RING entry produces no snooze until released and re-pressed.

Source files
------------

// File: rtl/alarm_snooze_ctrl.sv
// Alarm sequencer clocked by the 1 Hz pulse: ring on a rising alarm match,
// auto-silence after RING_SEC ticks, minute-based snooze with a per-event limit.
module alarm_snooze_ctrl #(
  parameter int SNOOZE_MIN = 9,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarmon,
  input  logic       snooze,
  input  logic       smax,
  input  logic [6:0] tmin,
  input  logic [6:0] thrs,
  input  logic       tpm,
  input  logic [6:0] amin,
  input  logic [6:0] ahrs,
  input  logic       apm,
  output logic       buzz,
  output logic       snoozing,
  output logic [3:0] snooze_left
);

  localparam int CW = $clog2(RING_SEC);
  localparam logic [CW-1:0] RING_LAST = CW'(RING_SEC - 1);
  localparam logic [3:0]    SNZ_LEN   = 4'(SNOOZE_MIN);
  localparam logic [1:0]    SNZ_MAX   = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t        state;
  logic          match;
  logic          match_q;
  logic          snooze_q;
  logic          trig;
  logic          snz_edge;
  logic [CW-1:0] ring_ct;
  logic [1:0]    snz_used;

  assign match    = (tmin == amin) && (thrs == ahrs) && (tpm == apm);
  assign trig     = alarmon && match && !match_q;
  assign snz_edge = snooze && !snooze_q;

  // Outputs decode the state register only; no input reaches them combinationally.
  assign buzz     = (state == RING);
  assign snoozing = (state == SNOOZE);

  // match_q resets high so a 12:00 AM == 12:00 AM match right after reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      match_q     <= 1'b1;
      snooze_q    <= 1'b0;
      ring_ct     <= '0;
      snooze_left <= 4'd0;
      snz_used    <= 2'd0;
    end else begin
      match_q  <= match;
      snooze_q <= snooze;
      if (!alarmon) begin
        state       <= IDLE;
        ring_ct     <= '0;
        snooze_left <= 4'd0;
        snz_used    <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            if (trig) begin
              state    <= RING;
              ring_ct  <= '0;
              snz_used <= 2'd0;
            end
          end
          RING: begin
            if (snz_edge && (snz_used < SNZ_MAX)) begin
              state       <= SNOOZE;
              ring_ct     <= '0;
              snooze_left <= SNZ_LEN;
              snz_used    <= snz_used + 2'd1;
            end else if (snz_edge || (ring_ct == RING_LAST)) begin
              // Dismiss on an over-limit snooze, or auto-silence at the ring limit.
              state   <= IDLE;
              ring_ct <= '0;
            end else begin
              ring_ct <= ring_ct + CW'(1);
            end
          end
          SNOOZE: begin
            if (smax) begin
              if (snooze_left == 4'd1) begin
                state       <= RING;
                ring_ct     <= '0;
                snooze_left <= 4'd0;
              end else begin
                snooze_left <= snooze_left - 4'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Directed bench for alarm_snooze_ctrl at default parameters (9 min snooze, 60 s ring, 3 snoozes).
module tb_alarm_snooze_ctrl;

  logic       clk;
  logic       rst;
  logic       alarmon;
  logic       snooze;
  logic       smax;
  logic [6:0] tmin;
  logic [6:0] thrs;
  logic       tpm;
  logic [6:0] amin;
  logic [6:0] ahrs;
  logic       apm;
  logic       buzz;
  logic       snoozing;
  logic [3:0] snooze_left;

  int checks = 0;
  int passed = 0;

  alarm_snooze_ctrl #(.SNOOZE_MIN(9), .RING_SEC(60), .MAX_SNOOZE(3)) dut (
    .clk(clk), .rst(rst), .alarmon(alarmon), .snooze(snooze), .smax(smax),
    .tmin(tmin), .thrs(thrs), .tpm(tpm), .amin(amin), .ahrs(ahrs), .apm(apm),
    .buzz(buzz), .snoozing(snoozing), .snooze_left(snooze_left)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected)
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    else
      passed++;
  endtask

  // Time reads 7:29, then the 7:30:00 tick changes minutes; buzz follows one tick later.
  task automatic start_ring(input string name);
    tmin = 7'd29;
    tick();
    tick();
    tmin = 7'd30;
    tick();
    check({name, "_buzz_on"}, {3'd0, buzz}, 4'd1);
  endtask

  task automatic press_snooze();
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
  endtask

  task automatic smax_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      smax = 1'b1;
      tick();
      smax = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; alarmon = 1'b1; snooze = 1'b0; smax = 1'b0;
    tmin = 7'd0; thrs = 7'd0; tpm = 1'b0;
    amin = 7'd0; ahrs = 7'd0; apm = 1'b0;
    #1;
    check("reset_buzz", {3'd0, buzz}, 4'd0);
    check("reset_snoozing", {3'd0, snoozing}, 4'd0);
    check("reset_snooze_left", snooze_left, 4'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_reset_no_ring", {3'd0, buzz}, 4'd0);
    end
  endtask

  task automatic test_ring_timeout();
    int high;
    amin = 7'd30; ahrs = 7'd7; apm = 1'b0;
    thrs = 7'd7; tpm = 1'b0;
    tmin = 7'd29;
    tick();
    tick();
    tmin = 7'd30;
    #1;
    check("no_ring_same_tick", {3'd0, buzz}, 4'd0);
    tick();
    check("ring_latency", {3'd0, buzz}, 4'd1);
    high = 1;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (buzz === 1'b1) high++;
    end
    check("ring_len_60", 4'(high == 60), 4'd1);
    check("silent_after_timeout", {3'd0, buzz}, 4'd0);
  endtask

  task automatic test_retrig_ignored();
    int high;
    start_ring("retrig");
    high = 1;
    for (int i = 0; i < 75; i++) begin
      if (i == 10) tmin = 7'd31;
      if (i == 12) tmin = 7'd30;
      tick();
      if (buzz === 1'b1) high++;
    end
    check("retrig_ring_len_60", 4'(high == 60), 4'd1);
  endtask

  task automatic test_snooze();
    start_ring("snz");
    for (int i = 0; i < 5; i++) tick();
    press_snooze();
    check("snz_buzz_off", {3'd0, buzz}, 4'd0);
    check("snz_snoozing", {3'd0, snoozing}, 4'd1);
    check("snz_left_9", snooze_left, 4'd9);
    smax_pulses(1);
    check("snz_left_8", snooze_left, 4'd8);
    smax_pulses(7);
    check("snz_left_1", snooze_left, 4'd1);
    check("snz_still_quiet", {3'd0, buzz}, 4'd0);
    smax = 1'b1;
    tick();
    smax = 1'b0;
    check("snz_rering", {3'd0, buzz}, 4'd1);
    check("snz_rering_left", snooze_left, 4'd0);
    check("snz_rering_snoozing", {3'd0, snoozing}, 4'd0);
  endtask

  // Continues from the RING left by test_snooze (one snooze already used).
  task automatic test_max_snooze();
    for (int n = 2; n <= 3; n++) begin
      tick();
      press_snooze();
      check("max_snz_enter", {3'd0, snoozing}, 4'd1);
      smax_pulses(9);
      check("max_snz_rering", {3'd0, buzz}, 4'd1);
    end
    tick();
    press_snooze();
    check("dismiss_buzz", {3'd0, buzz}, 4'd0);
    check("dismiss_snoozing", {3'd0, snoozing}, 4'd0);
    for (int i = 0; i < 5; i++) begin
      smax_pulses(1);
      check("dismiss_stays_idle", {3'd0, buzz | snoozing}, 4'd0);
    end
  endtask

  task automatic test_alarmon_drop();
    start_ring("drop");
    tick();
    tick();
    alarmon = 1'b0;
    tick();
    check("drop_buzz_off", {3'd0, buzz}, 4'd0);
    alarmon = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drop_no_rering", {3'd0, buzz}, 4'd0);
    end
  endtask

  task automatic test_timeout_snooze();
    start_ring("tsnz");
    for (int i = 0; i < 59; i++) tick();
    check("tsnz_last_ring_cycle", {3'd0, buzz}, 4'd1);
    snooze = 1'b1;
    tick();
    check("tsnz_snooze_wins", {3'd0, snoozing}, 4'd1);
    check("tsnz_left", snooze_left, 4'd9);
    smax_pulses(9);
    check("tsnz_rering", {3'd0, buzz}, 4'd1);
    for (int i = 0; i < 3; i++) tick();
    check("held_no_snooze", {3'd0, buzz}, 4'd1);
    snooze = 1'b0;
    tick();
    snooze = 1'b1;
    tick();
    check("repress_snoozing", {3'd0, snoozing}, 4'd1);
    check("repress_buzz", {3'd0, buzz}, 4'd0);
    snooze = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    alarmon = 1'b0;
    tick();
    alarmon = 1'b1;
    start_ring("arst");
    #2;
    rst = 1'b1;
    #1;
    check("arst_buzz_async", {3'd0, buzz}, 4'd0);
    check("arst_snoozing", {3'd0, snoozing}, 4'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("arst_no_ring", {3'd0, buzz}, 4'd0);
    end
  endtask

  initial begin
    test_reset();
    test_ring_timeout();
    test_retrig_ignored();
    test_snooze();
    test_max_snooze();
    test_alarmon_drop();
    test_timeout_snooze();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
